// File: rtl/mem_pkg.sv
// Shared memory-side constants: DMA state encodings and word-size helpers.
package mem_pkg;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] READ  = 2'd1;
  localparam logic [1:0] WRITE = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam logic [31:0] WORD_BYTES = 32'd4;

  function automatic logic is_word_aligned(input logic [31:0] addr);
    return (addr & (WORD_BYTES - 32'd1)) == 32'd0;
  endfunction

endpackage

// File: rtl/dma_copy.sv
// Word-at-a-time memory-to-memory copy engine: one READ then one WRITE cycle per word,
// driving a dmem with asynchronous read and synchronous write.
module dma_copy
  import mem_pkg::*;
#(
  parameter int unsigned LEN_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [31:0]      src,
  input  logic [31:0]      dst,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             mem_we,
  output logic [31:0]      mem_a,
  output logic [31:0]      mem_wd,
  input  logic [31:0]      mem_rd
);

  logic [1:0]       state_q, state_d;
  logic [31:0]      sp_q, dp_q, rd_buf_q;
  logic [LEN_W-1:0] cnt_q;
  logic             err_q;
  logic             req_ok;

  assign req_ok = is_word_aligned(src) && is_word_aligned(dst);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = (len == '0 || !req_ok) ? DONE : READ;
      READ:    state_d = WRITE;
      WRITE:   state_d = (cnt_q == LEN_W'(1)) ? DONE : READ;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      sp_q     <= '0;
      dp_q     <= '0;
      cnt_q    <= '0;
      rd_buf_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            sp_q  <= src;
            dp_q  <= dst;
            cnt_q <= len;
            // Misaligned requests are flagged here so err is already valid in DONE.
            err_q <= !req_ok;
          end
        end
        READ: begin
          rd_buf_q <= mem_rd;
          sp_q     <= sp_q + WORD_BYTES;
        end
        WRITE: begin
          dp_q  <= dp_q + WORD_BYTES;
          cnt_q <= cnt_q - LEN_W'(1);
        end
        default: ;
      endcase
    end
  end

  // Memory port is a pure decode of state and registers, never of start or mem_rd.
  always_comb begin
    mem_we = 1'b0;
    mem_a  = '0;
    mem_wd = '0;
    unique case (state_q)
      READ: mem_a = sp_q;
      WRITE: begin
        mem_we = 1'b1;
        mem_a  = dp_q;
        mem_wd = rd_buf_q;
      end
      default: ;
    endcase
  end

  assign busy = (state_q == READ) || (state_q == WRITE);
  assign done = (state_q == DONE);
  assign err  = err_q;

endmodule

// File: tb/tb_dma_copy.sv
// Randomized self-checking bench for dma_copy against a per-cycle behavioural copy model.
module tb_dma_copy;

  localparam int unsigned LEN_W = 8;
  localparam int          MW    = 256;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [31:0]      src, dst;
  logic [LEN_W-1:0] len;
  logic             busy, done, err, mem_we;
  logic [31:0]      mem_a, mem_wd, mem_rd;

  logic [31:0] tb_mem  [MW];
  logic [31:0] ref_mem [MW];

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  dma_copy #(.LEN_W(LEN_W)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .src    (src),
    .dst    (dst),
    .len    (len),
    .busy   (busy),
    .done   (done),
    .err    (err),
    .mem_we (mem_we),
    .mem_a  (mem_a),
    .mem_wd (mem_wd),
    .mem_rd (mem_rd)
  );

  // Data memory: asynchronous read, synchronous write, 1 KiB window aliased over the space.
  assign mem_rd = tb_mem[mem_a[9:2]];
  always @(posedge clk) if (mem_we) tb_mem[mem_a[9:2]] <= mem_wd;

  function automatic int widx(input logic [31:0] base, input int j);
    logic [31:0] a;
    a = base + 32'(4 * j);
    return int'(a[9:2]);
  endfunction

  // Behavioural model: m_mode 0 = waiting, 1 = copying (m_k = cycle 1..2N), 2 = completion cycle.
  int          m_mode = 0;
  int          m_k    = 0;
  int          m_n    = 0;
  logic [31:0] m_src  = '0;
  logic [31:0] m_dst  = '0;
  logic        m_err  = 1'b0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_mode <= 0;
      m_k    <= 0;
      m_err  <= 1'b0;
    end else begin
      case (m_mode)
        0: if (start) begin
          m_src <= src;
          m_dst <= dst;
          m_n   <= int'(len);
          m_err <= (src[1:0] != 2'b00) || (dst[1:0] != 2'b00);
          if ((src[1:0] != 2'b00) || (dst[1:0] != 2'b00) || len == '0) m_mode <= 2;
          else begin
            m_mode <= 1;
            m_k    <= 1;
          end
        end
        1: begin
          if (m_k % 2 == 0)
            ref_mem[widx(m_dst, m_k / 2 - 1)] <= ref_mem[widx(m_src, m_k / 2 - 1)];
          if (m_k == 2 * m_n) m_mode <= 2;
          else m_k <= m_k + 1;
        end
        default: m_mode <= 0;
      endcase
    end
  end

  always @(negedge clk) begin
    logic        e_busy, e_done, e_we;
    logic [31:0] e_a, e_wd;
    int          j;
    e_busy = (m_mode == 1);
    e_done = (m_mode == 2);
    e_we   = (m_mode == 1) && (m_k % 2 == 0);
    j      = (m_k % 2 == 0) ? (m_k / 2 - 1) : ((m_k - 1) / 2);
    e_a    = !e_busy ? 32'd0 : (e_we ? m_dst + 32'(4 * j) : m_src + 32'(4 * j));
    e_wd   = e_we ? ref_mem[widx(m_src, j)] : 32'd0;
    vectors++;
    if (busy !== e_busy || done !== e_done || mem_we !== e_we || mem_a !== e_a
        || mem_wd !== e_wd || (e_done && err !== m_err)) begin
      miscompares++;
      $display("FAIL cycle t=%0t busy/done/err/we/a/wd got %b %b %b %b %h %h expected %b %b %b %b %h %h",
               $time, busy, done, err, mem_we, mem_a, mem_wd,
               e_busy, e_done, e_done ? m_err : err, e_we, e_a, e_wd);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic poke(input int i, input logic [31:0] v);
    tb_mem[i]  = v;
    ref_mem[i] = v;
  endtask

  task automatic check_mem(input string name);
    int bad = 0;
    for (int i = 0; i < MW; i++) if (tb_mem[i] !== ref_mem[i]) bad++;
    check(name, 32'(bad), 32'd0);
  endtask

  task automatic run_job(input logic [31:0] s, input logic [31:0] d, input logic [7:0] n,
                         input bit noisy, output int busy_c, output int done_at,
                         output int done_c, output int we_c, output logic done_err);
    int active;
    busy_c = 0; done_at = 0; done_c = 0; we_c = 0; done_err = 1'b0;
    active = (s[1:0] != 2'b00 || d[1:0] != 2'b00 || n == 8'd0) ? 0 : 2 * int'(n);
    @(posedge clk); #1;
    src = s; dst = d; len = n; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    if (noisy) begin src = $urandom; dst = $urandom; len = 8'($urandom); end
    for (int c = 1; c <= 2 * int'(n) + 4; c++) begin
      @(negedge clk);
      if (busy) busy_c++;
      if (mem_we) we_c++;
      if (done) begin
        done_c++;
        if (done_at == 0) begin done_at = c; done_err = err; end
      end
      if (noisy && c <= active) begin
        if (c == 2) begin src = 32'h0; dst = 32'h380; len = 8'd2; start = 1'b1; end
        else begin
          start = 1'($urandom_range(0, 1));
          src = $urandom; dst = $urandom; len = 8'($urandom);
        end
      end else start = 1'b0;
    end
    start = 1'b0;
  endtask

  int   bc, da, dc, wc;
  logic de;

  initial begin
    reset = 1'b1; start = 1'b0; src = '0; dst = '0; len = '0;
    for (int i = 0; i < MW; i++) begin
      logic [31:0] v;
      v = $urandom;
      tb_mem[i] = v; ref_mem[i] = v;
    end
    repeat (2) @(posedge clk);
    #1;
    check("reset busy/done/err", {29'd0, busy, done, err}, 32'd0);
    check("reset mem_we", {31'd0, mem_we}, 32'd0);
    check("reset mem_a", mem_a, 32'd0);
    check("reset mem_wd", mem_wd, 32'd0);
    reset = 1'b0;

    // Basic three-word copy.
    poke(0, 32'hA); poke(1, 32'hB); poke(2, 32'hC);
    run_job(32'h0, 32'h40, 8'd3, 1'b0, bc, da, dc, wc, de);
    check("basic busy cycles", 32'(bc), 32'd6);
    check("basic done cycle", 32'(da), 32'd7);
    check("basic done count", 32'(dc), 32'd1);
    check("basic err", {31'd0, de}, 32'd0);
    check("basic writes", 32'(wc), 32'd3);
    check("basic ram16", tb_mem[16], 32'hA);
    check("basic ram17", tb_mem[17], 32'hB);
    check("basic ram18", tb_mem[18], 32'hC);

    // Zero length.
    run_job(32'h0, 32'h40, 8'd0, 1'b0, bc, da, dc, wc, de);
    check("zero done cycle", 32'(da), 32'd1);
    check("zero busy", 32'(bc), 32'd0);
    check("zero writes", 32'(wc), 32'd0);
    check("zero err", {31'd0, de}, 32'd0);

    // Misaligned source.
    run_job(32'h2, 32'h40, 8'd4, 1'b0, bc, da, dc, wc, de);
    check("misaligned done cycle", 32'(da), 32'd1);
    check("misaligned err", {31'd0, de}, 32'd1);
    check("misaligned writes", 32'(wc), 32'd0);
    check("misaligned busy", 32'(bc), 32'd0);

    // Start while busy is ignored.
    poke(64, 32'h11); poke(65, 32'h22); poke(66, 32'h33); poke(224, 32'hDEADBEEF);
    run_job(32'h100, 32'h300, 8'd3, 1'b1, bc, da, dc, wc, de);
    check("busy-start done count", 32'(dc), 32'd1);
    check("busy-start ram192", tb_mem[192], 32'h11);
    check("busy-start ram194", tb_mem[194], 32'h33);
    check("busy-start untouched", tb_mem[224], 32'hDEADBEEF);
    check_mem("busy-start image");

    // Reset in the second WRITE cycle.
    for (int i = 0; i < 4; i++) begin poke(64 + i, 32'(i + 1)); poke(128 + i, 32'h0); end
    @(posedge clk); #1;
    src = 32'h100; dst = 32'h200; len = 8'd4; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("midreset mem_we", {31'd0, mem_we}, 32'd0);
    check("midreset busy", {31'd0, busy}, 32'd0);
    check("midreset mem_a", mem_a, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    dc = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (done) dc++;
    end
    check("midreset no done", 32'(dc), 32'd0);
    check("midreset ram128", tb_mem[128], 32'd1);
    check("midreset ram129", tb_mem[129], 32'd0);
    check_mem("midreset image");

    // Overlap with dst below src.
    for (int i = 0; i < 4; i++) poke(1 + i, 32'(i + 1));
    run_job(32'h4, 32'h0, 8'd4, 1'b0, bc, da, dc, wc, de);
    for (int i = 0; i < 4; i++) check("overlap word", tb_mem[i], 32'(i + 1));

    // Source address wraps through zero.
    poke(254, 32'h5A0); poke(255, 32'h5A1); poke(0, 32'h5A2); poke(1, 32'h5A3);
    run_job(32'hFFFF_FFF8, 32'h80, 8'd4, 1'b0, bc, da, dc, wc, de);
    check("wrap word0", tb_mem[32], 32'h5A0);
    check("wrap word2", tb_mem[34], 32'h5A2);
    check("wrap word3", tb_mem[35], 32'h5A3);

    for (int t = 0; t < 30; t++) begin
      int          si, di, n;
      logic [31:0] s, d;
      bit          mis;
      si = $urandom_range(0, 200);
      di = $urandom_range(0, 200);
      n  = $urandom_range(0, 12);
      if (di > si && di < si + n) di = si;
      s = 32'(4 * si);
      d = 32'(4 * di);
      mis = ($urandom_range(0, 4) == 0);
      if (mis) begin
        if ($urandom_range(0, 1) == 1) s = s + 32'($urandom_range(1, 3));
        else d = d + 32'($urandom_range(1, 3));
      end
      run_job(s, d, 8'(n), 1'($urandom_range(0, 1)), bc, da, dc, wc, de);
      check("rand done count", 32'(dc), 32'd1);
      check("rand busy cycles", 32'(bc), (mis || n == 0) ? 32'd0 : 32'(2 * n));
      check("rand done cycle", 32'(da), (mis || n == 0) ? 32'd1 : 32'(2 * n + 1));
      check("rand err", {31'd0, de}, {31'd0, mis});
      check_mem("rand image");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dma_copy.md
DMA_COPY -- requirements
Module: dma_copy

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, on ports clk and reset.
REQ-002 Parameter LEN_W, default 8, SHALL set the width of the word-count input.
REQ-003 Port clk, input, 1 bit: rising-edge clock.
REQ-004 Port reset, input, 1 bit: asynchronous active-high reset.
REQ-005 Port start, input, 1 bit: request a copy; sampled only in IDLE.
REQ-006 Port src, input, 32 bits: byte address of the source; must be word aligned.
REQ-007 Port dst, input, 32 bits: byte address of the destination; must be word aligned.
REQ-008 Port len, input, LEN_W bits: number of 32-bit words to copy.
REQ-009 Port busy, output, 1 bit: high while in READ or WRITE.
REQ-010 Port done, output, 1 bit: one-cycle pulse when a copy completes or is rejected.
REQ-011 Port err, output, 1 bit: valid with done; high means the request was rejected for misalignment.
REQ-012 Port mem_we, output, 1 bit: data-memory write enable.
REQ-013 Port mem_a, output, 32 bits: data-memory byte address.
REQ-014 Port mem_wd, output, 32 bits: data-memory write data.
REQ-015 Port mem_rd, input, 32 bits: data-memory read data, combinational from mem_a (asynchronous read, synchronous write).

Function
REQ-016 The FSM SHALL have four states: IDLE, READ, WRITE and DONE.
REQ-017 In IDLE with start=1, the block SHALL latch src, dst and len into sp, dp and cnt, and clear err.
- len=0 or misalignment SHALL go to DONE.
- Otherwise the FSM SHALL go to READ.
REQ-018 Misalignment (src[1:0]!=0 or dst[1:0]!=0) SHALL set err=1 in DONE and perform no memory access.
REQ-019 In READ, mem_a SHALL equal sp and mem_we SHALL be 0.
- At the clock edge: buf<=mem_rd, sp<=sp+4, then go to WRITE.
REQ-020 In WRITE, mem_a SHALL equal dp, mem_wd SHALL equal buf and mem_we SHALL be 1.
- At the clock edge: dp<=dp+4, cnt<=cnt-1.
- Go to DONE if cnt==1, else go to READ.
REQ-021 DONE SHALL last exactly one cycle with done=1, then go to IDLE.
REQ-022 Outside WRITE, mem_we SHALL be 0 and mem_wd SHALL be 0; outside READ and WRITE, mem_a SHALL be 0.
REQ-023 Address increments SHALL be modulo 2^32; 0xFFFFFFFC+4 SHALL wrap to 0.
REQ-024 A copy of N words SHALL take exactly 2N cycles in READ/WRITE plus 1 DONE cycle; busy SHALL be high for 2N cycles.
REQ-025 start asserted in READ, WRITE or DONE SHALL be ignored and not queued.
REQ-026 Changes to src, dst or len after acceptance SHALL NOT affect the copy in progress.
REQ-027 The copy SHALL proceed in ascending order, one word at a time.
- Overlap with dst<=src SHALL copy correctly.
- Overlap with dst>src is unsupported, with no defined result.
REQ-028 mem_we, mem_a and mem_wd SHALL be decoded from state and registers only, never from start or mem_rd.

Reset
REQ-029 reset=1 SHALL force IDLE immediately, asynchronously, including mid-copy.
REQ-030 Reset SHALL set to 0: sp, dp, cnt, buf, err, done, busy, mem_we, mem_a and mem_wd.
REQ-031 A copy interrupted by reset SHALL NOT resume; words already written stay written and no done pulse SHALL be issued.

Structure
REQ-032 The state encodings (IDLE=2'd0, READ=2'd1, WRITE=2'd2, DONE=2'd3) and the word-size constant 4 SHALL live in the shared package mem_pkg.
REQ-033 The block SHALL be a single module with no sub-modules; the bench SHALL connect it to the team's dmem for checking.

Verification
REQ-034 Basic copy: preload RAM[0..2]=0xA,0xB,0xC; src=0, dst=0x40, len=3 -> RAM[16..18]=0xA,0xB,0xC; busy high 6 cycles; done on cycle 7; err=0.
REQ-035 Zero length: len=0, src=0, dst=0x40 -> done one cycle after start; mem_we never 1; busy never 1.
REQ-036 Misaligned: src=0x2, len=4 -> done one cycle after start with err=1; mem_we never 1.
REQ-037 Start while busy: pulse start mid-copy with a different dst -> ignored; only the original destination is written; a single done pulse.
REQ-038 Reset mid-copy: len=4, assert reset in the second WRITE cycle -> immediately mem_we=0, state IDLE, busy=0; only RAM[dst/4] written; no done pulse.
REQ-039 Overlap: RAM[1..4]=1,2,3,4; src=4, dst=0, len=4 -> RAM[0..3]=1,2,3,4.
